// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: forwarding select codes, hazard FSM states,
// and a register-match helper that treats x0 as never matching.
package hazard_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } state_t;

    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Per-operand forwarding select; purely combinational, MEM outranks WB.
// No backpressure: the result is consumed by the EX operand mux.
module fwd_sel
    import hazard_unit_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_wb,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_wb,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_reg_wb && reg_match(mem_rd, src)) begin
            sel = FWD_MEM;
        end else if (wb_reg_wb && reg_match(wb_rd, src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stall FSM, branch flush, operand forwarding.
// Controls are combinational in the current cycle; stalls hold PC/IF-ID and bubble ID/EX.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_wb,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_wb,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_wb,
    input  logic        branch_taken,
    output logic        stall,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt
);

    localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        hz;
    logic        load_stall;
    logic [1:0]  fwd_a_raw, fwd_b_raw;

    assign hz = ex_is_load && ex_reg_wb && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall       = 1'b0;
        pc_hold     = 1'b0;
        if_id_hold  = 1'b0;
        if_id_flush = 1'b0;
        load_stall  = 1'b0;

        if (branch_taken) begin
            // Redirect wins over any pending load bubbles.
            if_id_flush = 1'b1;
            stall       = 1'b1;
            state_d     = RUN;
            cnt_d       = 3'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz) begin
                        load_stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = LSTALL;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
                LSTALL: begin
                    load_stall = 1'b1;
                    cnt_d      = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            endcase
            stall      = load_stall;
            pc_hold    = load_stall;
            if_id_hold = load_stall;
        end

        // Controls read low for the whole time reset is held.
        if (reset) begin
            stall       = 1'b0;
            pc_hold     = 1'b0;
            if_id_hold  = 1'b0;
            if_id_flush = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (load_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= 3'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    fwd_sel u_fwd_a (
        .src        (ex_rs1),
        .mem_rd     (mem_rd),
        .mem_reg_wb (mem_reg_wb),
        .wb_rd      (wb_rd),
        .wb_reg_wb  (wb_reg_wb),
        .sel        (fwd_a_raw)
    );

    fwd_sel u_fwd_b (
        .src        (ex_rs2),
        .mem_rd     (mem_rd),
        .mem_reg_wb (mem_reg_wb),
        .wb_rd      (wb_rd),
        .wb_reg_wb  (wb_reg_wb),
        .sel        (fwd_b_raw)
    );

    assign fwd_a     = reset ? FWD_RF : fwd_a_raw;
    assign fwd_b     = reset ? FWD_RF : fwd_b_raw;
    assign stall_cnt = stall_cnt_q;

endmodule
